// File: rtl/rice_core_data_memory_responder_pkg.sv
// Shared types and helpers for the core's load/store port and its data memory responder.
package rice_core_pkg;

  typedef enum logic [1:0] {
    ACCESS_NONE  = 2'b00,
    ACCESS_STORE = 2'b01,
    ACCESS_LOAD  = 2'b10
  } rice_core_memory_access_type;

  // Encodings follow the RISC-V funct3 load/store widths.
  typedef enum logic [2:0] {
    MODE_B  = 3'b000,
    MODE_H  = 3'b001,
    MODE_W  = 3'b010,
    MODE_BU = 3'b100,
    MODE_HU = 3'b101
  } rice_core_memory_access_mode;

  typedef struct packed {
    rice_core_memory_access_type access_type;
    logic [2:0]                  access_mode;
  } rice_core_memory_access;

  typedef struct packed {
    rice_core_memory_access access;
    logic [31:0]            address;
    logic [31:0]            write_data;
  } rice_core_memory_request;

  typedef struct packed {
    logic [31:0] read_data;
    logic        error;
  } rice_core_memory_response;

  typedef enum logic [1:0] {
    STATE_IDLE    = 2'b00,
    STATE_WAIT    = 2'b01,
    STATE_RESPOND = 2'b10
  } rice_core_responder_state;

  function automatic logic [3:0] get_byte_strobe(input logic [2:0] mode,
                                                 input logic [1:0] lane);
    logic [3:0] strobe;
    case (rice_core_memory_access_mode'(mode))
      MODE_B, MODE_BU: strobe = 4'b0001 << lane;
      MODE_H, MODE_HU: strobe = 4'b0011 << lane;
      MODE_W:          strobe = 4'b1111;
      default:         strobe = 4'b0000;
    endcase
    return strobe;
  endfunction

endpackage

// File: rtl/rice_core_data_memory_responder_if.sv
// Request/response handshake between the memory-access stage (master) and the data memory (slave).
interface rice_core_data_memory_responder_if;

  logic        request_valid;
  logic        request_ready;
  logic [1:0]  access_type;
  logic [2:0]  access_mode;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        response_valid;
  logic        response_ready;
  logic [31:0] read_data;
  logic        error;

  modport master (
    output request_valid,
    output access_type,
    output access_mode,
    output address,
    output write_data,
    output response_ready,
    input  request_ready,
    input  response_valid,
    input  read_data,
    input  error
  );

  modport slave (
    input  request_valid,
    input  access_type,
    input  access_mode,
    input  address,
    input  write_data,
    input  response_ready,
    output request_ready,
    output response_valid,
    output read_data,
    output error
  );

endinterface

// File: rtl/rice_core_data_memory_responder_lane_steering.sv
// Combinational byte-lane steering: store strobes and replication, load extraction and
// extension, plus misalignment and illegal-mode detection.
module rice_core_memory_lane_steering
  import rice_core_pkg::*;
(
  input  rice_core_memory_access_type access_type,
  input  logic [2:0]                  access_mode,
  input  logic [1:0]                  lane,
  input  logic [31:0]                 write_data,
  input  logic [31:0]                 memory_word,
  output logic [3:0]                  byte_strobe,
  output logic [31:0]                 write_word,
  output logic [31:0]                 load_data,
  output logic                        misaligned,
  output logic                        illegal_mode
);

  logic [31:0] shifted_word;

  assign byte_strobe  = get_byte_strobe(access_mode, lane);
  assign shifted_word = memory_word >> {lane, 3'b000};

  // Unsigned modes only make sense for loads, so a BU/HU store is rejected here.
  always_comb begin
    write_word   = write_data;
    load_data    = memory_word;
    misaligned   = 1'b0;
    illegal_mode = 1'b0;
    case (rice_core_memory_access_mode'(access_mode))
      MODE_B: begin
        write_word = {4{write_data[7:0]}};
        load_data  = {{24{shifted_word[7]}}, shifted_word[7:0]};
      end
      MODE_BU: begin
        write_word   = {4{write_data[7:0]}};
        load_data    = {24'h000000, shifted_word[7:0]};
        illegal_mode = (access_type == ACCESS_STORE);
      end
      MODE_H: begin
        write_word = {2{write_data[15:0]}};
        load_data  = {{16{shifted_word[15]}}, shifted_word[15:0]};
        misaligned = lane[0];
      end
      MODE_HU: begin
        write_word   = {2{write_data[15:0]}};
        load_data    = {16'h0000, shifted_word[15:0]};
        misaligned   = lane[0];
        illegal_mode = (access_type == ACCESS_STORE);
      end
      MODE_W: begin
        write_word = write_data;
        load_data  = memory_word;
        misaligned = (lane != 2'b00);
      end
      default: begin
        load_data    = 32'h00000000;
        illegal_mode = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/rice_core_data_memory_responder.sv
// Single-outstanding data memory behind a valid/ready request/response handshake, with a
// programmable wait-state latency between accept and response.
module rice_core_data_memory_responder
  import rice_core_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 1,
  parameter string       INIT_FILE = ""
) (
  input logic                              i_clk,
  input logic                              i_rst_n,
  rice_core_data_memory_responder_if.slave mem_bus
);

  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
  localparam logic [3:0]  WAIT_INIT  = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  rice_core_responder_state state_q;
  rice_core_responder_state state_d;

  rice_core_memory_request  live_req;
  rice_core_memory_request  req_q;
  rice_core_memory_request  commit_req;
  rice_core_memory_response response_q;
  rice_core_memory_response response_d;

  logic [3:0]            wait_count_q;
  logic                  accept;
  logic                  commit;
  logic                  is_store;
  logic                  is_load;
  logic                  out_of_range;
  logic                  access_error;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] commit_index;
  logic [31:0]           mem_word;
  logic [31:0]           write_word;
  logic [31:0]           load_data;
  logic [3:0]            byte_strobe;
  logic                  misaligned;
  logic                  illegal_mode;

  logic [31:0] mem [DEPTH];

  always_comb begin
    live_req                    = '0;
    live_req.access.access_type = rice_core_memory_access_type'(mem_bus.access_type);
    live_req.access.access_mode = mem_bus.access_mode;
    live_req.address            = mem_bus.address;
    live_req.write_data         = mem_bus.write_data;
  end

  assign accept = mem_bus.request_valid && (state_q == STATE_IDLE);

  // With zero wait states the access commits in the accept cycle, straight off the bus.
  assign commit_req = (LATENCY == 0) ? live_req : req_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= STATE_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      STATE_IDLE: begin
        if (accept) begin
          state_d = (LATENCY == 0) ? STATE_RESPOND : STATE_WAIT;
        end
      end
      STATE_WAIT: begin
        if (wait_count_q == 4'd0) begin
          state_d = STATE_RESPOND;
        end
      end
      STATE_RESPOND: begin
        if (mem_bus.response_ready) begin
          state_d = STATE_IDLE;
        end
      end
      default: state_d = STATE_IDLE;
    endcase
  end

  // Commit is held off while reset is asserted so an aborted store never lands.
  always_comb begin
    mem_bus.request_ready  = (state_q == STATE_IDLE);
    mem_bus.response_valid = (state_q == STATE_RESPOND);
    commit                 = 1'b0;
    if (i_rst_n) begin
      if (state_q == STATE_IDLE) begin
        commit = accept && (LATENCY == 0);
      end else if (state_q == STATE_WAIT) begin
        commit = (wait_count_q == 4'd0);
      end
    end
  end

  rice_core_memory_lane_steering u_lane_steering (
    .access_type  (commit_req.access.access_type),
    .access_mode  (commit_req.access.access_mode),
    .lane         (commit_req.address[1:0]),
    .write_data   (commit_req.write_data),
    .memory_word  (mem_word),
    .byte_strobe  (byte_strobe),
    .write_word   (write_word),
    .load_data    (load_data),
    .misaligned   (misaligned),
    .illegal_mode (illegal_mode)
  );

  assign is_store     = (commit_req.access.access_type == ACCESS_STORE);
  assign is_load      = (commit_req.access.access_type == ACCESS_LOAD);
  assign out_of_range = ({2'b00, commit_req.address[31:2]} >= 32'(DEPTH));
  assign access_error = (is_store || is_load) && (misaligned || illegal_mode || out_of_range);
  assign commit_index = commit_req.address[ADDR_WIDTH+1:2];
  assign mem_word     = mem[commit_index];
  assign mem_write    = commit && is_store && !access_error;

  always_comb begin
    response_d           = '0;
    response_d.read_data = (is_load && !access_error) ? load_data : 32'h00000000;
    response_d.error     = access_error;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      req_q        <= '0;
      wait_count_q <= 4'd0;
      response_q   <= '0;
    end else begin
      if (accept) begin
        req_q        <= live_req;
        wait_count_q <= WAIT_INIT;
      end else if ((state_q == STATE_WAIT) && (wait_count_q != 4'd0)) begin
        wait_count_q <= wait_count_q - 4'd1;
      end
      if (commit) begin
        response_q <= response_d;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (mem_write) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_strobe[b]) begin
          mem[commit_index][8*b +: 8] <= write_word[8*b +: 8];
        end
      end
    end
  end

  assign mem_bus.read_data = response_q.read_data;
  assign mem_bus.error     = response_q.error;

endmodule

// File: tb/tb_rice_core_data_memory_responder.sv
// Bench for the data memory responder: a vector table on a LATENCY=1 instance, plus
// back-pressure and reset-abort sequences (the latter on a LATENCY=4 instance).
module tb_rice_core_data_memory_responder;
  import rice_core_pkg::*;

  localparam int unsigned DEPTH   = 1024;
  localparam int          TIMEOUT = 50;

  typedef struct {
    string       name;
    logic [1:0]  access_type;
    logic [2:0]  access_mode;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] exp_data;
    logic        exp_error;
  } vector_t;

  logic    clk = 1'b0;
  logic    rst_n;
  logic    rst4_n;
  int      checks = 0;
  int      passes = 0;
  vector_t exp_q[$];
  vector_t vectors[$];

  rice_core_data_memory_responder_if bus();
  rice_core_data_memory_responder_if bus4();

  rice_core_data_memory_responder #(
    .DEPTH(DEPTH), .LATENCY(1), .INIT_FILE("")
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .mem_bus(bus)
  );

  rice_core_data_memory_responder #(
    .DEPTH(DEPTH), .LATENCY(4), .INIT_FILE("")
  ) dut4 (
    .i_clk(clk), .i_rst_n(rst4_n), .mem_bus(bus4)
  );

  always #5 clk = ~clk;

  function automatic vector_t mk(input string name, input logic [1:0] t, input logic [2:0] m,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input logic [31:0] ed, input logic ee);
    vector_t v;
    v.name = name; v.access_type = t; v.access_mode = m; v.address = a;
    v.write_data = wd; v.exp_data = ed; v.exp_error = ee;
    return v;
  endfunction

  function automatic logic readyOf(input bit slow);
    return slow ? bus4.request_ready : bus.request_ready;
  endfunction

  function automatic logic validOf(input bit slow);
    return slow ? bus4.response_valid : bus.response_valid;
  endfunction

  function automatic logic [31:0] dataOf(input bit slow);
    return slow ? bus4.read_data : bus.read_data;
  endfunction

  function automatic logic errorOf(input bit slow);
    return slow ? bus4.error : bus.error;
  endfunction

  task automatic checkValue(input string name, input logic [31:0] actual,
                            input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  task automatic driveRequest(input bit slow, input logic valid, input vector_t v);
    if (slow) begin
      bus4.request_valid = valid; bus4.access_type = v.access_type;
      bus4.access_mode = v.access_mode; bus4.address = v.address;
      bus4.write_data = v.write_data;
    end else begin
      bus.request_valid = valid; bus.access_type = v.access_type;
      bus.access_mode = v.access_mode; bus.address = v.address;
      bus.write_data = v.write_data;
    end
  endtask

  task automatic setResponseReady(input bit slow, input logic value);
    if (slow) bus4.response_ready = value;
    else bus.response_ready = value;
  endtask

  // Present a request, wait (bounded) for ready, and queue its expected response.
  task automatic applyStimulus(input bit slow, input vector_t v);
    int waited = 0;
    @(negedge clk);
    driveRequest(slow, 1'b1, v);
    while (!readyOf(slow) && waited < TIMEOUT) begin
      @(negedge clk);
      waited++;
    end
    if (!readyOf(slow)) begin
      checkValue({v.name, " accept timeout"}, 32'(readyOf(slow)), 32'd1);
      driveRequest(slow, 1'b0, v);
      return;
    end
    exp_q.push_back(v);
    @(posedge clk);
    #1 driveRequest(slow, 1'b0, v);
  endtask

  // Wait for the response, compare latency/data/error against the scoreboard, then handshake.
  task automatic checkOutput(input bit slow, input int latency);
    vector_t v;
    int      cycles = 0;
    if (exp_q.size() == 0) return;
    v = exp_q.pop_front();
    do begin
      @(negedge clk);
      cycles++;
    end while (!validOf(slow) && cycles < TIMEOUT);
    checkValue({v.name, " latency"}, 32'(cycles), 32'(latency + 1));
    checkValue({v.name, " read_data"}, dataOf(slow), v.exp_data);
    checkValue({v.name, " error"}, 32'(errorOf(slow)), 32'(v.exp_error));
    setResponseReady(slow, 1'b1);
    @(posedge clk);
    #1 setResponseReady(slow, 1'b0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vector_t v1;
    vector_t v2;
    int      cycles;

    vectors.push_back(mk("sw 0x10",       ACCESS_STORE, MODE_W,  32'h10,   32'h11223344, 32'h0,        1'b0));
    vectors.push_back(mk("lw 0x10",       ACCESS_LOAD,  MODE_W,  32'h10,   32'h0,        32'h11223344, 1'b0));
    vectors.push_back(mk("sb 0x13",       ACCESS_STORE, MODE_B,  32'h13,   32'h12345680, 32'h0,        1'b0));
    vectors.push_back(mk("lb 0x13",       ACCESS_LOAD,  MODE_B,  32'h13,   32'h0,        32'hFFFFFF80, 1'b0));
    vectors.push_back(mk("lbu 0x13",      ACCESS_LOAD,  MODE_BU, 32'h13,   32'h0,        32'h00000080, 1'b0));
    vectors.push_back(mk("lw 0x10 sb",    ACCESS_LOAD,  MODE_W,  32'h10,   32'h0,        32'h80223344, 1'b0));
    vectors.push_back(mk("lh 0x11 mis",   ACCESS_LOAD,  MODE_H,  32'h11,   32'h0,        32'h0,        1'b1));
    vectors.push_back(mk("sw 0x12 mis",   ACCESS_STORE, MODE_W,  32'h12,   32'hDEADBEEF, 32'h0,        1'b1));
    vectors.push_back(mk("lw 0x10 kept",  ACCESS_LOAD,  MODE_W,  32'h10,   32'h0,        32'h80223344, 1'b0));
    vectors.push_back(mk("sh 0x16",       ACCESS_STORE, MODE_H,  32'h16,   32'h0000A5B6, 32'h0,        1'b0));
    vectors.push_back(mk("lh 0x16",       ACCESS_LOAD,  MODE_H,  32'h16,   32'h0,        32'hFFFFA5B6, 1'b0));
    vectors.push_back(mk("lhu 0x16",      ACCESS_LOAD,  MODE_HU, 32'h16,   32'h0,        32'h0000A5B6, 1'b0));
    vectors.push_back(mk("shu illegal",   ACCESS_STORE, MODE_HU, 32'h16,   32'h00001111, 32'h0,        1'b1));
    vectors.push_back(mk("lhu 0x16 kept", ACCESS_LOAD,  MODE_HU, 32'h16,   32'h0,        32'h0000A5B6, 1'b0));
    vectors.push_back(mk("sw 0x18",       ACCESS_STORE, MODE_W,  32'h18,   32'h7F00FF01, 32'h0,        1'b0));
    vectors.push_back(mk("lb 0x18",       ACCESS_LOAD,  MODE_B,  32'h18,   32'h0,        32'h00000001, 1'b0));
    vectors.push_back(mk("lb 0x19",       ACCESS_LOAD,  MODE_B,  32'h19,   32'h0,        32'hFFFFFFFF, 1'b0));
    vectors.push_back(mk("lh 0x1a",       ACCESS_LOAD,  MODE_H,  32'h1A,   32'h0,        32'h00007F00, 1'b0));
    vectors.push_back(mk("lbu 0x1b",      ACCESS_LOAD,  MODE_BU, 32'h1B,   32'h0,        32'h0000007F, 1'b0));
    vectors.push_back(mk("sw last word",  ACCESS_STORE, MODE_W,  32'hFFC,  32'hA1B2C3D4, 32'h0,        1'b0));
    vectors.push_back(mk("lw last word",  ACCESS_LOAD,  MODE_W,  32'hFFC,  32'h0,        32'hA1B2C3D4, 1'b0));
    vectors.push_back(mk("lw range",      ACCESS_LOAD,  MODE_W,  32'h1000, 32'h0,        32'h0,        1'b1));
    vectors.push_back(mk("mode 111",      ACCESS_LOAD,  3'b111,  32'h10,   32'h0,        32'h0,        1'b1));
    vectors.push_back(mk("sw mode 110",   ACCESS_STORE, 3'b110,  32'h10,   32'h0,        32'h0,        1'b1));
    vectors.push_back(mk("lw 0x10 final", ACCESS_LOAD,  MODE_W,  32'h10,   32'h0,        32'h80223344, 1'b0));
    vectors.push_back(mk("type none",     ACCESS_NONE,  MODE_W,  32'h10,   32'h55AA55AA, 32'h0,        1'b0));

    v1 = mk("idle", ACCESS_NONE, MODE_W, 32'h0, 32'h0, 32'h0, 1'b0);
    driveRequest(1'b0, 1'b0, v1);
    driveRequest(1'b1, 1'b0, v1);
    setResponseReady(1'b0, 1'b0);
    setResponseReady(1'b1, 1'b0);
    rst_n  = 1'b0;
    rst4_n = 1'b0;
    repeat (3) @(negedge clk);
    checkValue("reset request_ready", 32'(bus.request_ready), 32'd1);
    checkValue("reset response_valid", 32'(bus.response_valid), 32'd0);
    checkValue("reset read_data", bus.read_data, 32'h0);
    checkValue("reset error", 32'(bus.error), 32'd0);
    checkValue("reset4 request_ready", 32'(bus4.request_ready), 32'd1);
    checkValue("reset4 response_valid", 32'(bus4.response_valid), 32'd0);
    rst_n  = 1'b1;
    rst4_n = 1'b1;

    $display("[TB] running %0d table vectors", vectors.size());
    foreach (vectors[i]) begin
      applyStimulus(1'b0, vectors[i]);
      checkOutput(1'b0, 1);
    end

    // Back-pressure: response held 5 cycles while a second request waits.
    v1 = mk("bp lw 0x10", ACCESS_LOAD, MODE_W,  32'h10, 32'h0, 32'h80223344, 1'b0);
    v2 = mk("bp lbu 0x10", ACCESS_LOAD, MODE_BU, 32'h10, 32'h0, 32'h00000044, 1'b0);
    applyStimulus(1'b0, v1);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!bus.response_valid && cycles < TIMEOUT);
    checkValue("bp latency", 32'(cycles), 32'd2);
    driveRequest(1'b0, 1'b1, v2);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      checkValue("bp valid held", 32'(bus.response_valid), 32'd1);
      checkValue("bp data stable", bus.read_data, v1.exp_data);
      checkValue("bp ready low", 32'(bus.request_ready), 32'd0);
    end
    setResponseReady(1'b0, 1'b1);
    @(posedge clk);
    #1 setResponseReady(1'b0, 1'b0);
    @(negedge clk);
    checkValue("bp idle after handshake", 32'(bus.request_ready), 32'd1);
    checkValue("bp valid dropped", 32'(bus.response_valid), 32'd0);
    exp_q.push_back(v2);
    @(posedge clk);
    #1 driveRequest(1'b0, 1'b0, v2);
    checkOutput(1'b0, 1);

    // LATENCY=4: committed store persists, store aborted by reset mid-WAIT does not land.
    applyStimulus(1'b1, mk("l4 sw prior", ACCESS_STORE, MODE_W, 32'h20, 32'h01020304, 32'h0, 1'b0));
    checkOutput(1'b1, 4);
    v1 = mk("l4 sw aborted", ACCESS_STORE, MODE_W, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0);
    @(negedge clk);
    driveRequest(1'b1, 1'b1, v1);
    checkValue("l4 ready before abort", 32'(bus4.request_ready), 32'd1);
    @(posedge clk);
    #1 driveRequest(1'b1, 1'b0, v1);
    @(negedge clk);
    checkValue("l4 wait ready low", 32'(bus4.request_ready), 32'd0);
    @(negedge clk);
    rst4_n = 1'b0;
    @(negedge clk);
    checkValue("l4 abort ready", 32'(bus4.request_ready), 32'd1);
    checkValue("l4 abort valid", 32'(bus4.response_valid), 32'd0);
    rst4_n = 1'b1;
    applyStimulus(1'b1, mk("l4 lw after abort", ACCESS_LOAD, MODE_W, 32'h20, 32'h0, 32'h01020304, 1'b0));
    checkOutput(1'b1, 4);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
